// File: rtl/spi_process_param.sv
// Serial word receiver with message-atomic data/length FIFOs, plus a serial word transmitter.
// RX word lands 1 cycle after its last bit; FIFO_Q 1 cycle after RD_REQ; overflowing messages are dropped, TX ignores ENA while BUSY.

module spi_process_param_fifo #(
   parameter int W  = 8,
   parameter int AW = 2
) (
   input  logic         core_clk,
   input  logic         arst_n,
   input  logic         push_vld,
   input  logic [W-1:0] push_dat,
   input  logic         pop_vld,
   output logic [W-1:0] head_dat,
   output logic         full,
   output logic         empty
);
   // Show-ahead FIFO: head_dat is the oldest entry, zero when empty.
   // A push is visible the cycle after; push when full and pop when empty are ignored.

   localparam int DEPTH = 1 << AW;

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wp;
   logic [AW:0]  rp;

   assign empty    = (wp == rp);
   assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign head_dat = empty ? '0 : mem[rp[AW-1:0]];

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push_vld && !full)
            wp <= wp + (AW+1)'(1);
         if (pop_vld && !empty)
            rp <= rp + (AW+1)'(1);
      end
   end

   always_ff @(posedge core_clk) begin
      if (push_vld && !full)
         mem[wp[AW-1:0]] <= push_dat;
   end

endmodule

module spi_process_param #(
   parameter int DATA_W  = 16,
   parameter int FIFO_AW = 8,
   parameter int LEN_W   = 8,
   parameter int MSG_AW  = 2,
   parameter int CLK_DIV = 4
) (
   input  logic              SYS_CLK,
   input  logic              RST,
   input  logic              RX_CLK,
   input  logic              RX_DATA,
   input  logic              RX_LOAD,
   input  logic              RX_STOP,
   input  logic              RD_REQ,
   input  logic              RD_REQ_LEN,
   output logic [DATA_W-1:0] FIFO_Q,
   output logic [LEN_W-1:0]  msg_len_out,
   output logic              GOT_FULL_MSG,
   output logic              DROP,
   input  logic [DATA_W-1:0] DATA,
   input  logic              ENA,
   input  logic              LAST,
   output logic              BUSY,
   output logic              TX_CLK,
   output logic              TX_DATA,
   output logic              TX_LOAD,
   output logic              TX_STOP
);

   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam int DEPTH = 1 << FIFO_AW;

   // ---------------- receive: synchronisers and deserialiser ----------------
   logic [1:0] clk_sy, dat_sy, load_sy, stop_sy;
   logic       clk_q;
   logic       rx_rise;
   logic       eom;

   logic [DATA_W-1:0] rx_shift;
   logic [BIT_W-1:0]  bit_cnt;
   logic              wr_pend;

   always_ff @(posedge SYS_CLK or negedge RST) begin
      if (!RST) begin
         clk_sy  <= '0;
         dat_sy  <= '0;
         load_sy <= '0;
         stop_sy <= '0;
         clk_q   <= 1'b0;
      end else begin
         clk_sy  <= {clk_sy[0], RX_CLK};
         dat_sy  <= {dat_sy[0], RX_DATA};
         load_sy <= {load_sy[0], RX_LOAD};
         stop_sy <= {stop_sy[0], RX_STOP};
         clk_q   <= clk_sy[1];
      end
   end

   assign rx_rise = clk_sy[1] && !clk_q;
   assign eom     = rx_rise && stop_sy[1];

   // STOP wins over LOAD on the same edge, so a stop edge never completes a word.
   always_ff @(posedge SYS_CLK or negedge RST) begin
      if (!RST) begin
         rx_shift <= '0;
         bit_cnt  <= '0;
         wr_pend  <= 1'b0;
      end else begin
         wr_pend <= 1'b0;
         if (rx_rise) begin
            if (stop_sy[1]) begin
               bit_cnt <= '0;
            end else if (load_sy[1]) begin
               rx_shift <= {rx_shift[DATA_W-2:0], dat_sy[1]};
               if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                  bit_cnt <= '0;
                  wr_pend <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
         end
      end
   end

   // ---------------- receive: data FIFO with speculative write pointer ----------------
   logic [DATA_W-1:0] mem [DEPTH];
   logic [FIFO_AW:0]  spec_wp, com_wp, rd_ptr;
   logic [LEN_W-1:0]  msg_cnt;
   logic              msg_err;
   logic              d_full, d_empty;
   logic              wr_ok, commit, drop_now;
   logic              len_full, len_empty;

   assign d_full  = (spec_wp[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (spec_wp[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign d_empty = (com_wp == rd_ptr);

   assign wr_ok    = wr_pend && !msg_err && !d_full && (msg_cnt != '1);
   assign commit   = eom && !msg_err && (msg_cnt != '0) && !len_full;
   assign drop_now = eom && (msg_err || ((msg_cnt != '0) && len_full));

   always_ff @(posedge SYS_CLK or negedge RST) begin
      if (!RST) begin
         spec_wp <= '0;
         com_wp  <= '0;
         msg_cnt <= '0;
         msg_err <= 1'b0;
         DROP    <= 1'b0;
      end else begin
         DROP <= drop_now;
         if (wr_pend && !wr_ok)
            msg_err <= 1'b1;
         if (wr_ok) begin
            spec_wp <= spec_wp + (FIFO_AW+1)'(1);
            msg_cnt <= msg_cnt + LEN_W'(1);
         end
         if (eom) begin
            msg_cnt <= '0;
            msg_err <= 1'b0;
            if (commit)
               com_wp <= spec_wp;
            else
               spec_wp <= com_wp;
         end
      end
   end

   always_ff @(posedge SYS_CLK) begin
      if (wr_ok)
         mem[spec_wp[FIFO_AW-1:0]] <= rx_shift;
   end

   // Read side owns rd_ptr only, so a same-cycle commit and pop never conflict.
   always_ff @(posedge SYS_CLK or negedge RST) begin
      if (!RST) begin
         rd_ptr <= '0;
         FIFO_Q <= '0;
      end else if (RD_REQ && !d_empty) begin
         FIFO_Q <= mem[rd_ptr[FIFO_AW-1:0]];
         rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
      end
   end

   spi_process_param_fifo #(
      .W  (LEN_W),
      .AW (MSG_AW)
   ) u_len_fifo (
      .core_clk (SYS_CLK),
      .arst_n   (RST),
      .push_vld (commit),
      .push_dat (msg_cnt),
      .pop_vld  (RD_REQ_LEN),
      .head_dat (msg_len_out),
      .full     (len_full),
      .empty    (len_empty)
   );

   assign GOT_FULL_MSG = !len_empty;

   // ---------------- transmit ----------------
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_STOP} tx_state_t;

   tx_state_t         tx_st, tx_st_n;
   logic [DATA_W-1:0] tx_sh, tx_sh_n;
   logic              tx_last, tx_last_n;
   logic [BIT_W-1:0]  tx_bit, tx_bit_n;
   logic [DIV_W-1:0]  tx_div, tx_div_n;
   logic              period_end;

   always_ff @(posedge SYS_CLK or negedge RST) begin
      if (!RST) begin
         tx_st   <= ST_IDLE;
         tx_sh   <= '0;
         tx_last <= 1'b0;
         tx_bit  <= '0;
         tx_div  <= '0;
      end else begin
         tx_st   <= tx_st_n;
         tx_sh   <= tx_sh_n;
         tx_last <= tx_last_n;
         tx_bit  <= tx_bit_n;
         tx_div  <= tx_div_n;
      end
   end

   assign period_end = (tx_div == DIV_W'(2 * CLK_DIV - 1));

   always_comb begin
      tx_st_n   = tx_st;
      tx_sh_n   = tx_sh;
      tx_last_n = tx_last;
      tx_bit_n  = tx_bit;
      tx_div_n  = tx_div;
      BUSY      = 1'b0;
      TX_CLK    = 1'b0;
      TX_DATA   = 1'b0;
      TX_LOAD   = 1'b0;
      TX_STOP   = 1'b0;

      case (tx_st)
         ST_IDLE: begin
            if (ENA) begin
               tx_st_n   = ST_SHIFT;
               tx_sh_n   = DATA;
               tx_last_n = LAST;
               tx_bit_n  = '0;
               tx_div_n  = '0;
            end
         end
         ST_SHIFT: begin
            BUSY     = 1'b1;
            TX_CLK   = (tx_div >= DIV_W'(CLK_DIV));
            TX_DATA  = tx_sh[DATA_W-1];
            TX_LOAD  = 1'b1;
            tx_div_n = period_end ? '0 : tx_div + DIV_W'(1);
            if (period_end) begin
               if (tx_bit == BIT_W'(DATA_W - 1)) begin
                  tx_st_n = tx_last ? ST_STOP : ST_IDLE;
               end else begin
                  tx_bit_n = tx_bit + BIT_W'(1);
                  tx_sh_n  = {tx_sh[DATA_W-2:0], 1'b0};
               end
            end
         end
         ST_STOP: begin
            BUSY     = 1'b1;
            TX_CLK   = (tx_div >= DIV_W'(CLK_DIV));
            TX_STOP  = 1'b1;
            tx_div_n = period_end ? '0 : tx_div + DIV_W'(1);
            if (period_end)
               tx_st_n = ST_IDLE;
         end
         default: begin
            tx_st_n = ST_IDLE;
         end
      endcase
   end

endmodule
